// File: rtl/aap_fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aap_fetch_pkg : shared types and constants for the AAP instruction fetch unit
// Rev 1.0
// ----------------------------------------------------------------------------
package aap_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE_LO = 2'd0,
    WAIT_LO  = 2'd1,
    WAIT_HI  = 2'd2,
    OUT      = 2'd3
  } fetch_state_t;

  localparam int          DEFAULT_PC_W     = 24;
  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int          IS32_BIT         = 15;

endpackage
`default_nettype wire

// File: rtl/aap_fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aap_fetch_unit_if : instruction-memory read bus plus decoder handshake
// Rev 1.0
// ----------------------------------------------------------------------------
interface aap_fetch_unit_if
  import aap_fetch_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
);

  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_word;
  logic            instr_is32;
  logic [PC_W-1:0] instr_pc;

  // master: the fetch unit; slave: memory + decoder side
  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    output instr_valid, instr_word, instr_is32, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    input  instr_valid, instr_word, instr_is32, instr_pc,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/aap_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aap_fetch_unit : tick-enabled fetch of 16/32-bit instructions for the decoder
// Rev 1.0
// ----------------------------------------------------------------------------
module aap_fetch_unit
  import aap_fetch_pkg::*;
#(
  parameter int          PC_W     = DEFAULT_PC_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tick,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  aap_fetch_unit_if.master   bus,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_t     state, state_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic [15:0]      lo, lo_n;
  logic             rd_en, rd_en_n;
  logic [PC_W-1:0]  addr, addr_n;
  logic             valid, valid_n;
  logic [31:0]      word, word_n;
  logic             is32, is32_n;
  logic [PC_W-1:0]  ipc, ipc_n;
  logic [CNT_W-1:0] count, count_n;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ISSUE_LO;
      pc    <= PC_W'(RESET_PC);
      lo    <= '0;
      rd_en <= 1'b0;
      addr  <= '0;
      valid <= 1'b0;
      word  <= '0;
      is32  <= 1'b0;
      ipc   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      lo    <= lo_n;
      rd_en <= rd_en_n;
      addr  <= addr_n;
      valid <= valid_n;
      word  <= word_n;
      is32  <= is32_n;
      ipc   <= ipc_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    lo_n    = lo;
    rd_en_n = 1'b0;   // read strobe is a single-cycle pulse
    addr_n  = addr;
    valid_n = valid;
    word_n  = word;
    is32_n  = is32;
    ipc_n   = ipc;
    count_n = count;

    if (tick) begin
      if (redirect_valid) begin
        // Returning to ISSUE_LO drops any read still in flight
        pc_n    = redirect_pc;
        state_n = ISSUE_LO;
        valid_n = 1'b0;
      end else begin
        case (state)
          ISSUE_LO: begin
            if (!halt) begin
              rd_en_n = 1'b1;
              addr_n  = pc;
              state_n = WAIT_LO;
            end
          end
          WAIT_LO: begin
            lo_n = bus.imem_rdata;
            if (bus.imem_rdata[IS32_BIT]) begin
              rd_en_n = 1'b1;
              addr_n  = pc + PC_W'(1);
              state_n = WAIT_HI;
            end else begin
              word_n  = {16'h0000, bus.imem_rdata};
              is32_n  = 1'b0;
              valid_n = 1'b1;
              ipc_n   = pc;
              state_n = OUT;
            end
          end
          WAIT_HI: begin
            word_n  = {bus.imem_rdata, lo};
            is32_n  = 1'b1;
            valid_n = 1'b1;
            ipc_n   = pc;
            state_n = OUT;
          end
          OUT: begin
            if (bus.instr_ready) begin
              valid_n = 1'b0;
              pc_n    = pc + (is32 ? PC_W'(2) : PC_W'(1));
              count_n = count + CNT_W'(1);
              state_n = ISSUE_LO;
            end
          end
          default: state_n = ISSUE_LO;
        endcase
      end
    end
  end

  assign bus.imem_rd_en  = rd_en;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = valid;
  assign bus.instr_word  = word;
  assign bus.instr_is32  = is32;
  assign bus.instr_pc    = ipc;
  assign instr_count     = count;

endmodule
`default_nettype wire

// File: tb/tb_aap_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aap_fetch_unit : directed self-checking bench for aap_fetch_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_aap_fetch_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        tick;
  logic        halt;
  logic        redirect_valid;
  logic [23:0] redirect_pc;
  logic [15:0] instr_count;

  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  logic [23:0] last_rd = '0;
  logic [15:0] mem [bit [23:0]];

  aap_fetch_unit_if #(.PC_W(24)) bus ();

  aap_fetch_unit #(.PC_W(24), .RESET_PC(0), .CNT_W(16)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .tick           (tick),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .instr_count    (instr_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous instruction memory; also logs every read strobe cycle
  always @(posedge CLOCK_50) begin
    if (bus.imem_rd_en) begin
      bus.imem_rdata <= mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : 16'h0000;
      rd_cnt         <= rd_cnt + 1;
      last_rd        <= bus.imem_addr;
    end
  end

  task automatic step();
    @(negedge CLOCK_50); tick = 1'b1;
    @(negedge CLOCK_50); tick = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_word"},  bus.instr_word,        32'h0);
    chk({tag, "_is32"},  32'(bus.instr_is32),  32'h0);
    chk({tag, "_pc"},    32'(bus.instr_pc),    32'h0);
    chk({tag, "_count"}, 32'(instr_count),     32'h0);
    chk({tag, "_rd_en"}, 32'(bus.imem_rd_en),  32'h0);
    chk({tag, "_addr"},  32'(bus.imem_addr),   32'h0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    bus.instr_ready = 1'b1;
    mem[24'h000000] = 16'h1234;
    mem[24'h000001] = 16'h0042;
    repeat (3) @(negedge CLOCK_50);
    chk_reset_state("rst");
    reset = 1'b0;

    // Two 16-bit instructions back to back
    step();
    chk("t1_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("t1_rd_addr", 32'(last_rd), 32'h0);
    chk("t1_valid_early", 32'(bus.instr_valid), 32'h0);
    step();
    chk("t1_valid", 32'(bus.instr_valid), 32'h1);
    chk("t1_word", bus.instr_word, 32'h0000_1234);
    chk("t1_is32", 32'(bus.instr_is32), 32'h0);
    chk("t1_pc", 32'(bus.instr_pc), 32'h0);
    step();
    chk("t1_valid_drop", 32'(bus.instr_valid), 32'h0);
    chk("t1_count", 32'(instr_count), 32'd1);
    step();
    chk("t1b_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("t1b_rd_addr", 32'(last_rd), 32'h1);
    step();
    chk("t1b_word", bus.instr_word, 32'h0000_0042);
    chk("t1b_pc", 32'(bus.instr_pc), 32'h1);
    step();
    chk("t1b_count", 32'(instr_count), 32'd2);

    // 32-bit instruction, then a stall of 5 ticks
    mem[24'h000000] = 16'h8001;
    mem[24'h000001] = 16'hBEEF;
    mem[24'h000002] = 16'h0007;
    redirect_valid = 1'b1; redirect_pc = 24'h000000;
    step();
    redirect_valid = 1'b0;
    chk("t2_redir_no_issue", 32'(rd_cnt), 32'd2);
    step();
    chk("t2_rd_lo", 32'(last_rd), 32'h0);
    step();
    chk("t2_rd_hi", 32'(last_rd), 32'h1);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd4);
    chk("t2_valid_early", 32'(bus.instr_valid), 32'h0);
    bus.instr_ready = 1'b0;
    step();
    chk("t2_valid", 32'(bus.instr_valid), 32'h1);
    chk("t2_word", bus.instr_word, 32'hBEEF_8001);
    chk("t2_is32", 32'(bus.instr_is32), 32'h1);
    chk("t2_pc", 32'(bus.instr_pc), 32'h0);
    repeat (5) step();
    chk("t3_stall_valid", 32'(bus.instr_valid), 32'h1);
    chk("t3_stall_word", bus.instr_word, 32'hBEEF_8001);
    chk("t3_stall_pc", 32'(bus.instr_pc), 32'h0);
    chk("t3_stall_no_rd", 32'(rd_cnt), 32'd4);
    chk("t3_stall_count", 32'(instr_count), 32'd2);
    bus.instr_ready = 1'b1;
    step();
    chk("t3_acc_valid", 32'(bus.instr_valid), 32'h0);
    chk("t3_acc_count", 32'(instr_count), 32'd3);
    step();
    chk("t3_next_rd", 32'(last_rd), 32'h2);
    chk("t3_next_rd_cnt", 32'(rd_cnt), 32'd5);
    step();
    chk("t3_next_word", bus.instr_word, 32'h0000_0007);
    chk("t3_next_pc", 32'(bus.instr_pc), 32'h2);
    chk("t3_next_is32", 32'(bus.instr_is32), 32'h0);
    step();
    chk("t3_next_count", 32'(instr_count), 32'd4);

    // Redirect during WAIT_HI, then during OUT together with ready
    mem[24'h000003] = 16'h8003;
    mem[24'h000004] = 16'h1111;
    mem[24'h000100] = 16'h0055;
    step();
    chk("t4_rd_lo", 32'(last_rd), 32'h3);
    step();
    chk("t4_rd_hi", 32'(last_rd), 32'h4);
    redirect_valid = 1'b1; redirect_pc = 24'h000100;
    step();
    redirect_valid = 1'b0;
    chk("t4_whi_valid", 32'(bus.instr_valid), 32'h0);
    chk("t4_whi_count", 32'(instr_count), 32'd4);
    chk("t4_whi_rd_cnt", 32'(rd_cnt), 32'd7);
    step();
    chk("t4_rd_target", 32'(last_rd), 32'h100);
    chk("t4_rd_target_cnt", 32'(rd_cnt), 32'd8);
    step();
    chk("t4_out_valid", 32'(bus.instr_valid), 32'h1);
    chk("t4_out_word", bus.instr_word, 32'h0000_0055);
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("t4_out_redir_valid", 32'(bus.instr_valid), 32'h0);
    chk("t4_out_redir_count", 32'(instr_count), 32'd4);
    step();
    chk("t4_reissue", 32'(last_rd), 32'h100);
    chk("t4_reissue_cnt", 32'(rd_cnt), 32'd9);
    step();
    chk("t4_reout_pc", 32'(bus.instr_pc), 32'h100);
    step();
    chk("t4_acc_count", 32'(instr_count), 32'd5);

    // Halt blocks issue; then 32-bit fetch across the address wrap
    halt = 1'b1;
    repeat (3) step();
    chk("t5_halt_no_rd", 32'(rd_cnt), 32'd9);
    chk("t5_halt_valid", 32'(bus.instr_valid), 32'h0);
    halt = 1'b0;
    mem[24'hFFFFFF] = 16'h8ABC;
    mem[24'h000000] = 16'h1357;
    redirect_valid = 1'b1; redirect_pc = 24'hFFFFFF;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t5_wrap_rd_lo", 32'(last_rd), 32'hFFFFFF);
    step();
    chk("t5_wrap_rd_hi", 32'(last_rd), 32'h000000);
    step();
    chk("t5_wrap_word", bus.instr_word, 32'h1357_8ABC);
    chk("t5_wrap_is32", 32'(bus.instr_is32), 32'h1);
    chk("t5_wrap_pc", 32'(bus.instr_pc), 32'hFFFFFF);
    step();
    chk("t5_wrap_count", 32'(instr_count), 32'd6);
    step();
    chk("t5_pc_after_wrap", 32'(last_rd), 32'h000001);
    chk("t5_rd_cnt", 32'(rd_cnt), 32'd12);

    // Reset while in WAIT_LO, then clean restart from RESET_PC
    @(negedge CLOCK_50); reset = 1'b1;
    @(negedge CLOCK_50); reset = 1'b0;
    chk_reset_state("t6_rst");
    step();
    chk("t6_rd_addr", 32'(last_rd), 32'h0);
    chk("t6_rd_cnt", 32'(rd_cnt), 32'd13);
    step();
    chk("t6_valid", 32'(bus.instr_valid), 32'h1);
    chk("t6_word", bus.instr_word, 32'h0000_1357);
    chk("t6_pc", 32'(bus.instr_pc), 32'h0);
    step();
    chk("t6_count", 32'(instr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
